multiexp_job_sequencer: RTL

Sequences one multi-exponentiation job between the scalar/point AXI read streams, the multiexp core, and the result write stream. On a start pulse it latches the job length. It then joins scalar and point beats into lockstep pairs, frames them with sop/eop for the core, and counts exactly `i_num_in` pairs. After the last pair it forwards the result beats and reports completion. It sits between the read masters and the core input, and between the core output and the write master, and it owns `ap_done` generation for the kernel.

---
 rtl/multiexp_job_sequencer.sv | 98 +++++++++
 1 files changed

// File: rtl/multiexp_job_sequencer.sv
// multiexp_job_sequencer: joins scalar/point beats into framed core pairs, forwards result beats and raises done
module multiexp_job_sequencer #(
    parameter int SCL_BITS  = 256,
    parameter int PNT_BITS  = 512,
    parameter int RES_BITS  = 512,
    parameter int RES_BEATS = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [63:0]         i_num_in,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    input  logic                i_scl_val,
    output logic                o_scl_rdy,
    input  logic [SCL_BITS-1:0] i_scl_dat,
    input  logic                i_scl_eop,
    input  logic                i_pnt_val,
    output logic                o_pnt_rdy,
    input  logic [PNT_BITS-1:0] i_pnt_dat,
    input  logic                i_pnt_eop,
    output logic                o_pair_val,
    input  logic                i_pair_rdy,
    output logic [SCL_BITS-1:0] o_pair_scl,
    output logic [PNT_BITS-1:0] o_pair_pnt,
    output logic                o_pair_sop,
    output logic                o_pair_eop,
    input  logic                i_res_val,
    output logic                o_res_rdy,
    input  logic [RES_BITS-1:0] i_res_dat,
    output logic                o_wr_val,
    input  logic                i_wr_rdy,
    output logic [RES_BITS-1:0] o_wr_dat,
    output logic                o_wr_eop
);
    localparam int RW = RES_BEATS > 1 ? $clog2(RES_BEATS) : 1;
    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [63:0] num, pair_cnt;
    logic [RW-1:0] res_cnt;
    logic busy, err, feed, drain, last, pair_hs, wr_hs, frame_bad;

    assign o_busy = busy;
    assign o_err  = err;

    always_comb begin
        feed       = state == FEED;
        drain      = state == DRAIN;
        last       = pair_cnt == num - 64'd1;
        o_pair_val = feed & i_scl_val & i_pnt_val;
        o_scl_rdy  = feed & i_pnt_val & i_pair_rdy;
        o_pnt_rdy  = feed & i_scl_val & i_pair_rdy;
        o_pair_sop = feed & (pair_cnt == '0);
        o_pair_eop = feed & last;
        o_pair_scl = i_scl_dat;
        o_pair_pnt = i_pnt_dat;
        pair_hs    = o_pair_val & i_pair_rdy;
        // the pair count decides framing; stream eop flags only feed the error flag
        frame_bad  = pair_hs & (last ? ~(i_scl_eop & i_pnt_eop) : (i_scl_eop | i_pnt_eop));
        o_wr_val   = drain & i_res_val;
        o_res_rdy  = drain & i_wr_rdy;
        o_wr_dat   = i_res_dat;
        o_wr_eop   = drain & (res_cnt == RW'(RES_BEATS - 1));
        wr_hs      = o_wr_val & i_wr_rdy;
        o_done     = state == DONE;
        state_nx   = state;
        case (state)
            IDLE:    if (i_start) state_nx = |i_num_in ? FEED : DONE;
            FEED:    if (pair_hs && last) state_nx = DRAIN;
            DRAIN:   if (wr_hs && o_wr_eop) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            err      <= 1'b0;
            num      <= '0;
            pair_cnt <= '0;
            res_cnt  <= '0;
        end else begin
            state <= state_nx;
            busy  <= state_nx == FEED || state_nx == DRAIN;
            if (state == IDLE && i_start) begin
                num      <= i_num_in;
                pair_cnt <= '0;
                res_cnt  <= '0;
                err      <= 1'b0;
            end
            if (pair_hs) pair_cnt <= pair_cnt + 64'd1;
            if (wr_hs) res_cnt <= res_cnt + RW'(1);
            if (frame_bad) err <= 1'b1;
        end
    end
endmodule
